// File: rtl/div_unit_if.sv
// Handshake and result bus between the controller and the signed divider.
interface div_unit_if;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        DivDone;
    logic        DivZero;
    logic [5:0]  counter;
    logic [31:0] HI;
    logic [31:0] LO;

    // Controller side: issues start requests and operands, reads results
    modport master (
        output DivCtrl, A, B,
        input  DivDone, DivZero, counter, HI, LO
    );

    // Divider side
    modport slave (
        input  DivCtrl, A, B,
        output DivDone, DivZero, counter, HI, LO
    );
endinterface

// File: rtl/div_unit.sv
// MIPS-style signed 32-bit divider: restoring shift-subtract on magnitudes,
// one quotient bit per cycle, sign fix-up at the end. LO = quotient, HI = remainder.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    div_unit_if.slave   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ZERO = 3'd4;

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;    // partial remainder
    logic [31:0] r_quo;    // dividend bits shift out the top, quotient bits shift in the bottom
    logic [31:0] r_dvs;    // divisor magnitude
    logic        r_sa;     // dividend sign
    logic        r_sb;     // divisor sign
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_zero;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude
    assign w_abs_a = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    assign w_abs_b = bus.B[31] ? (~bus.B + 32'd1) : bus.B;

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[32];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    // Control FSM, datapath registers and the delayed divide-by-zero pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvs   <= 32'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_zero  <= 1'b0;
        end else begin
            // DivZero goes high the cycle after ZERO is entered
            r_zero <= (r_state == S_ZERO);
            case (r_state)
                S_IDLE: begin
                    if (bus.DivCtrl) begin
                        if (bus.B != 32'd0) begin
                            r_quo   <= w_abs_a;
                            r_rem   <= 32'd0;
                            r_dvs   <= w_abs_b;
                            r_sa    <= bus.A[31];
                            r_sb    <= bus.B[31];
                            r_cnt   <= 6'd0;
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_ZERO;
                        end
                    end
                end
                S_CALC: begin
                    // 32 steps, then one cycle with counter parked at 32 before fix-up
                    if (r_cnt == 6'd32) begin
                        r_state <= S_FIX;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_FIX: begin
                    r_lo    <= (r_sa ^ r_sb) ? (~r_quo + 32'd1) : r_quo;
                    r_hi    <= r_sa ? (~r_rem + 32'd1) : r_rem;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_cnt   <= 6'd0;
                    r_state <= S_IDLE;
                end
                S_ZERO: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.DivDone = (r_state == S_DONE);
    assign bus.DivZero = r_zero;
    assign bus.counter = r_cnt;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands
// against a 64-bit arithmetic reference.
module tb_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    div_unit_if bus();
    div_unit dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Reference: signed truncating division on widened operands, so -2^31/-1 is safe
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Issue a start now (caller sits just after an edge), then observe 40 edges.
    // A/B are scrambled after the start edge; pulse_at>0 re-asserts DivCtrl with A=B=1 at that edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                           output int lat, output int zlat, output int ndone, output int nzero,
                           output logic [5:0] c16, output logic [5:0] c33);
        lat = 0; zlat = 0; ndone = 0; nzero = 0; c16 = '0; c33 = '0;
        bus.DivCtrl = 1'b1; bus.A = a; bus.B = b;
        @(posedge clock); #1;
        for (int i = 1; i <= 40; i++) begin
            if (i == pulse_at) begin
                bus.DivCtrl = 1'b1; bus.A = 32'd1; bus.B = 32'd1;
            end else begin
                bus.DivCtrl = 1'b0; bus.A = $urandom; bus.B = $urandom;
            end
            @(posedge clock); #1;
            if (bus.DivDone) begin ndone++; if (lat == 0) lat = i; end
            if (bus.DivZero) begin nzero++; if (zlat == 0) zlat = i; end
            if (i == 16) c16 = bus.counter;
            if (i == 33) c33 = bus.counter;
        end
        bus.DivCtrl = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.DivCtrl = 1'b1; bus.A = 32'd9; bus.B = 32'd3;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
        checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
        checks++; if (bus.counter !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.counter); end
        checks++; if (bus.DivDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.DivDone); end
        checks++; if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.DivZero); end
        reset = 1'b0; bus.DivCtrl = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.counter !== 6'd0) begin errors++; $display("FAIL idle_cnt got=%0d exp=0", bus.counter); end
    endtask

    task automatic test_basic();
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        run_div(32'd7, 32'd2, 0, lat, zlat, nd, nz, c16, c33);
        exp_lo = 32'd3; exp_hi = 32'd1;
        checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL basic_zero_count got=%0d exp=0", nz); end
        checks++; if (c16 !== 6'd16) begin errors++; $display("FAIL basic_cnt16 got=%0d exp=16", c16); end
        checks++; if (c33 !== 6'd32) begin errors++; $display("FAIL basic_cnt33 got=%0d exp=32", c33); end
        checks++; if (bus.LO !== exp_lo) begin errors++; $display("FAIL basic_lo got=%h exp=%h", bus.LO, exp_lo); end
        checks++; if (bus.HI !== exp_hi) begin errors++; $display("FAIL basic_hi got=%h exp=%h", bus.HI, exp_hi); end
        checks++; if (bus.counter !== 6'd0) begin errors++; $display("FAIL basic_cnt_idle got=%0d exp=0", bus.counter); end
    endtask

    task automatic test_signed();
        logic [31:0] av [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
        logic [31:0] bv [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] lo_e [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000003};
        logic [31:0] hi_e [3] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        for (int i = 0; i < 3; i++) begin
            run_div(av[i], bv[i], 0, lat, zlat, nd, nz, c16, c33);
            exp_lo = lo_e[i]; exp_hi = hi_e[i];
            checks++; if (bus.LO !== exp_lo) begin errors++; $display("FAIL signed%0d_lo got=%h exp=%h", i, bus.LO, exp_lo); end
            checks++; if (bus.HI !== exp_hi) begin errors++; $display("FAIL signed%0d_hi got=%h exp=%h", i, bus.HI, exp_hi); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL signed%0d_done got=%0d exp=1", i, nd); end
        end
    endtask

    task automatic test_div_zero();
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        run_div(32'd3, 32'd1, 0, lat, zlat, nd, nz, c16, c33);
        exp_lo = 32'd3; exp_hi = 32'd0;
        run_div(32'd5, 32'd0, 0, lat, zlat, nd, nz, c16, c33);
        checks++; if (zlat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", zlat); end
        checks++; if (nz !== 1) begin errors++; $display("FAIL zero_count got=%0d exp=1", nz); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL zero_done got=%0d exp=0", nd); end
        checks++; if (bus.LO !== exp_lo) begin errors++; $display("FAIL zero_lo got=%h exp=%h", bus.LO, exp_lo); end
        checks++; if (bus.HI !== exp_hi) begin errors++; $display("FAIL zero_hi got=%h exp=%h", bus.HI, exp_hi); end
    endtask

    task automatic test_overflow();
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        run_div(32'h80000000, 32'hFFFFFFFF, 0, lat, zlat, nd, nz, c16, c33);
        exp_lo = 32'h80000000; exp_hi = 32'h00000000;
        checks++; if (bus.LO !== exp_lo) begin errors++; $display("FAIL ovf_lo got=%h exp=%h", bus.LO, exp_lo); end
        checks++; if (bus.HI !== exp_hi) begin errors++; $display("FAIL ovf_hi got=%h exp=%h", bus.HI, exp_hi); end
        checks++; if (nd !== 1 || nz !== 0) begin errors++; $display("FAIL ovf_flags got=done%0d/zero%0d exp=1/0", nd, nz); end
    endtask

    task automatic test_ignore_start();
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        run_div(32'd100, 32'd7, 10, lat, zlat, nd, nz, c16, c33);
        exp_lo = 32'd14; exp_hi = 32'd2;
        checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done got=%0d exp=1", nd); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
        checks++; if (bus.LO !== exp_lo) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", bus.LO, exp_lo); end
        checks++; if (bus.HI !== exp_hi) begin errors++; $display("FAIL ignore_hi got=%h exp=%h", bus.HI, exp_hi); end
    endtask

    task automatic test_reset_mid();
        int nd, lat, zlat, nz; logic [5:0] c16, c33;
        nd = 0;
        bus.DivCtrl = 1'b1; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clock); #1;
        bus.DivCtrl = 1'b0;
        repeat (14) begin @(posedge clock); #1; if (bus.DivDone) nd++; end
        reset = 1'b1; bus.DivCtrl = 1'b1; bus.A = 32'd9; bus.B = 32'd3;
        @(posedge clock); #1;
        checks++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL rmid_hilo got=%h/%h exp=0/0", bus.HI, bus.LO); end
        checks++; if (bus.counter !== 6'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", bus.counter); end
        checks++; if (bus.DivDone !== 1'b0 || bus.DivZero !== 1'b0) begin errors++; $display("FAIL rmid_flags got=%b%b exp=00", bus.DivDone, bus.DivZero); end
        reset = 1'b0; bus.DivCtrl = 1'b0;
        repeat (40) begin @(posedge clock); #1; if (bus.DivDone) nd++; end
        exp_lo = 32'd0; exp_hi = 32'd0;
        checks++; if (nd !== 0) begin errors++; $display("FAIL rmid_nodone got=%0d exp=0", nd); end
        run_div(32'd9, 32'd3, 0, lat, zlat, nd, nz, c16, c33);
        exp_lo = 32'd3; exp_hi = 32'd0;
        checks++; if (bus.LO !== exp_lo || bus.HI !== exp_hi) begin errors++; $display("FAIL rmid_fresh got=%h/%h exp=%h/%h", bus.LO, bus.HI, exp_lo, exp_hi); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL rmid_fresh_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_random();
        int lat, zlat, nd, nz; logic [5:0] c16, c33;
        logic [31:0] a, b; logic [63:0] r;
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_div(a, b, 0, lat, zlat, nd, nz, c16, c33);
            if (b != 32'd0) begin
                r = ref_div(a, b);
                exp_hi = r[63:32]; exp_lo = r[31:0];
            end
            checks++;
            if (bus.LO !== exp_lo || bus.HI !== exp_hi || nd !== (b != 0 ? 1 : 0) || nz !== (b == 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h got lo=%h hi=%h d=%0d z=%0d exp lo=%h hi=%h", n, a, b, bus.LO, bus.HI, nd, nz, exp_lo, exp_hi);
            end
        end
    endtask

    initial begin
        bus.DivCtrl = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 SHALL have ports: DivCtrl  in  1  start request from Controle; sampled only in IDLE.
REQ-004 SHALL have ports: A  in  32  dividend (register A output), two's complement.
REQ-005 SHALL have ports: B  in  32  divisor (register B output), two's complement.
REQ-006 SHALL have ports: DivDone  out  1  one-cycle pulse; HI/LO hold a new valid result.
REQ-007 SHALL have ports: DivZero  out  1  one-cycle pulse; divisor was zero, no result produced.
REQ-008 SHALL have ports: counter  out  6  iteration count, 0..32, for debug and trace.
REQ-009 SHALL have ports: HI  out  32  remainder, feeds MuxHICtrl input 0.
REQ-010 SHALL have ports: LO  out  32  quotient, feeds MuxLOCtrl input 0.

Function
REQ-011 SHALL implement MIPS signed div: LO = A/B truncated toward zero; HI = A - LO*B; remainder sign = dividend sign.
REQ-012 SHALL use FSM states IDLE, CALC, FIX, DONE, ZERO.
REQ-013 IDLE: on an edge with DivCtrl=1 and B!=0, SHALL latch |A|, |B| and both sign bits, clear counter, and enter CALC.
REQ-014 IDLE: on an edge with DivCtrl=1 and B==0, SHALL enter ZERO; HI/LO unchanged.
REQ-015 CALC: SHALL perform one restoring shift-subtract step per cycle on 32-bit unsigned magnitudes, increment counter, and enter FIX after 32 steps (counter=32).
REQ-016 FIX: SHALL negate quotient if signs differ, negate remainder if dividend negative, register results into HI/LO, and enter DONE.
REQ-017 DONE: SHALL assert DivDone for exactly one cycle, then return to IDLE.
REQ-018 ZERO: SHALL assert DivZero for exactly one cycle with DivDone=0, then return to IDLE.
REQ-019 Latency: start sampled at edge k; DivDone SHALL be high between edges k+34 and k+35; HI/LO valid from edge k+34.
REQ-020 Latency: divide-by-zero start at edge k; DivZero SHALL be high between edges k+1 and k+2.
REQ-021 SHALL ignore DivCtrl in every state other than IDLE; operands are not re-latched mid-operation.
REQ-022 SHALL use only latched operands after the start edge; A/B changes after start SHALL NOT affect the result.
REQ-023 Overflow case A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with DivDone and no DivZero.
REQ-024 HI/LO SHALL hold their last result until the next FIX; DivZero SHALL NOT modify them.
REQ-025 counter SHALL read 0 in IDLE/ZERO and hold 32 in FIX/DONE.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, with HI=0, LO=0, counter=0, DivDone=0, DivZero=0, in any state.
REQ-027 Reset mid-CALC SHALL abort without a DivDone pulse; DivCtrl in the same cycle as reset SHALL be ignored.

Verification
REQ-028 A=7, B=2, DivCtrl pulse -> DivDone at start+34 edges, LO=0x00000003, HI=0x00000001.
REQ-029 Signed cases, each checked for correct quotient and remainder:
- A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- A=7, B=-2 -> LO=0xFFFFFFFD, HI=0x00000001.
- A=-7, B=-2 -> LO=0x00000003, HI=0xFFFFFFFF.
REQ-030 Prior result 3/1, then A=5, B=0, DivCtrl -> DivZero pulse one cycle after start, no DivDone, HI/LO remain 0x00000000/0x00000003.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DivZero=0.
REQ-032 Start 100/7, then at start+10 pulse DivCtrl with A=1, B=1 and change A/B -> single DivDone, LO=14, HI=2.
REQ-033 Start 100/7, then reset at start+15 -> all outputs 0 next cycle, no DivDone; a fresh 9/3 afterwards -> LO=3, HI=0.
